// File: rtl/rom_fetch_unit.sv
// rtl/rom_fetch_unit.sv - instruction fetch front end for an 8-bit registered-read program ROM
// Sequential prefetch into a shift-register FIFO with single-cycle redirect flush.
module rom_fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  input  logic [7:0]            ROM_DATA,
  input  logic                  JUMP,
  input  logic [ADDR_WIDTH-1:0] JUMP_ADDR,
  output logic [7:0]            INSTR,
  output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fpc_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pend_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         occ;
  logic [CW-1:0]         wr_idx;
  logic                  valid_q;
  logic [7:0]            data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic                  issue;
  logic                  push;
  logic                  pop;

  assign ROM_ADDR = (JUMP && RESETN) ? JUMP_ADDR : fpc_q;

  // Occupancy counts the in-flight read so the FIFO can never overflow.
  assign occ    = count_q + CW'(pend_q);
  assign issue  = RESETN && (JUMP || (occ < CW'(DEPTH)));
  assign push   = pend_q && !JUMP;
  assign pop    = valid_q && INSTR_READY;
  assign wr_idx = pop ? (count_q - CW'(1)) : count_q;

  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      fpc_q   <= '0;
      paddr_q <= '0;
      pend_q  <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      if (issue) begin
        pend_q  <= 1'b1;
        paddr_q <= ROM_ADDR;
        fpc_q   <= ROM_ADDR + ADDR_WIDTH'(1);
      end else begin
        pend_q  <= 1'b0;
      end

      // Head lives in entry 0; a pop shifts everything down one slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (CW'(i) == wr_idx)) begin
          data_q[i] <= ROM_DATA;
          addr_q[i] <= paddr_q;
        end else if (pop && (i < DEPTH - 1)) begin
          data_q[i] <= data_q[i+1];
          addr_q[i] <= addr_q[i+1];
        end
      end

      if (JUMP) begin
        count_q <= '0;
        valid_q <= 1'b0;
      end else begin
        count_q <= count_nxt;
        valid_q <= (count_nxt != '0);
      end
    end
  end

  assign INSTR       = data_q[0];
  assign INSTR_ADDR  = addr_q[0];
  assign INSTR_VALID = valid_q;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb/tb_rom_fetch_unit.sv - directed bench for rom_fetch_unit
// ROM model returns address + 0x10 one cycle after the address is presented.
module tb_rom_fetch_unit;

  logic       CLK;
  logic       RESETN;
  logic [7:0] ROM_ADDR;
  logic [7:0] ROM_DATA;
  logic       JUMP;
  logic [7:0] JUMP_ADDR;
  logic [7:0] INSTR;
  logic [7:0] INSTR_ADDR;
  logic       INSTR_VALID;
  logic       INSTR_READY;

  int total = 0;
  int bad   = 0;

  rom_fetch_unit #(.ADDR_WIDTH(8), .DEPTH(4)) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .ROM_ADDR    (ROM_ADDR),
    .ROM_DATA    (ROM_DATA),
    .JUMP        (JUMP),
    .JUMP_ADDR   (JUMP_ADDR),
    .INSTR       (INSTR),
    .INSTR_ADDR  (INSTR_ADDR),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) ROM_DATA <= ROM_ADDR + 8'h10;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] a;
    RESETN      = 1'b0;
    JUMP        = 1'b0;
    JUMP_ADDR   = 8'h00;
    INSTR_READY = 1'b1;
    tick();
    tick();
    JUMP      = 1'b1;
    JUMP_ADDR = 8'h55;
    #1;
    chk("rst_rom_addr_jump_ignored", ROM_ADDR, 8'h00);
    tick();
    chk("rst_valid", INSTR_VALID, 1'b0);
    chk("rst_instr", INSTR, 8'h00);
    chk("rst_instr_addr", INSTR_ADDR, 8'h00);
    JUMP   = 1'b0;
    RESETN = 1'b1;
    #1;
    chk("c0_rom_addr", ROM_ADDR, 8'h00);
    chk("c0_valid", INSTR_VALID, 1'b0);
    tick();
    chk("c1_valid", INSTR_VALID, 1'b0);
    chk("c1_rom_addr", ROM_ADDR, 8'h01);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("start_valid", INSTR_VALID, 1'b1);
      chk("start_addr", INSTR_ADDR, i);
      chk("start_instr", INSTR, 8'h10 + i);
      tick();
    end

    INSTR_READY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", INSTR_VALID, 1'b1);
      chk("bp_addr_hold", INSTR_ADDR, 8'h06);
      chk("bp_instr_hold", INSTR, 8'h16);
      if (i >= 3) chk("bp_rom_addr_stall", ROM_ADDR, 8'h0A);
      tick();
    end
    INSTR_READY = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("resume_valid", INSTR_VALID, 1'b1);
      chk("resume_addr", INSTR_ADDR, 8'h06 + i);
      tick();
    end

    INSTR_READY = 1'b0;
    chk("pre_jump_addr", INSTR_ADDR, 8'h0E);
    tick();
    JUMP      = 1'b1;
    JUMP_ADDR = 8'h80;
    #1;
    chk("jump_rom_addr", ROM_ADDR, 8'h80);
    chk("jump_head_hold", INSTR_ADDR, 8'h0E);
    tick();
    JUMP = 1'b0;
    chk("jump_j1_valid", INSTR_VALID, 1'b0);
    INSTR_READY = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("jump_valid", INSTR_VALID, 1'b1);
      chk("jump_addr", INSTR_ADDR, 8'h80 + i);
      chk("jump_instr", INSTR, 8'h90 + i);
      tick();
    end

    chk("hs_head_addr", INSTR_ADDR, 8'h84);
    JUMP      = 1'b1;
    JUMP_ADDR = 8'h40;
    tick();
    JUMP = 1'b0;
    chk("hs_j1_valid", INSTR_VALID, 1'b0);
    tick();
    chk("hs_valid", INSTR_VALID, 1'b1);
    chk("hs_addr0", INSTR_ADDR, 8'h40);
    chk("hs_instr0", INSTR, 8'h50);
    tick();
    chk("hs_addr1", INSTR_ADDR, 8'h41);

    JUMP      = 1'b1;
    JUMP_ADDR = 8'hFE;
    tick();
    JUMP = 1'b0;
    chk("wrap_j1_valid", INSTR_VALID, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      a = 8'hFE + 8'(i);
      chk("wrap_valid", INSTR_VALID, 1'b1);
      chk("wrap_addr", INSTR_ADDR, a);
      chk("wrap_instr", INSTR, 8'(a + 8'h10));
      tick();
    end

    INSTR_READY = 1'b0;
    tick();
    tick();
    RESETN = 1'b0;
    tick();
    RESETN      = 1'b1;
    INSTR_READY = 1'b1;
    #1;
    chk("mrst_valid", INSTR_VALID, 1'b0);
    chk("mrst_instr", INSTR, 8'h00);
    chk("mrst_instr_addr", INSTR_ADDR, 8'h00);
    chk("mrst_rom_addr", ROM_ADDR, 8'h00);
    tick();
    chk("mrst_c1_valid", INSTR_VALID, 1'b0);
    tick();
    chk("mrst_c2_valid", INSTR_VALID, 1'b1);
    chk("mrst_c2_addr", INSTR_ADDR, 8'h00);
    chk("mrst_c2_instr", INSTR, 8'h10);
    tick();
    chk("mrst_c3_addr", INSTR_ADDR, 8'h01);
    chk("mrst_c3_instr", INSTR, 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_fetch_unit.md
# rom_fetch_unit

Instruction fetch front end between the 8-bit registered-read program ROM and the processor's decode stage. Generates sequential ROM read addresses and absorbs the ROM's one-cycle read latency. Buffers fetched bytes in a small prefetch FIFO and hands them to the processor over a valid/ready handshake, tagged with their address. Supports single-cycle redirect (jump/branch), which flushes all prefetched and in-flight data.

## Interface
- ADDR_WIDTH, 8: ROM address width; the fetch address wraps modulo 2**ADDR_WIDTH.
- DEPTH, 4: prefetch FIFO depth; power of two, ≥2.

- CLK  in  1  system clock; all state updates on the rising edge.
- RESETN  in  1  synchronous, active-low reset.
- ROM_ADDR  out  ADDR_WIDTH  read address to the ROM, sampled by the ROM on the rising edge.
- ROM_DATA  in  8  ROM read data; valid in the cycle after its address was presented.
- JUMP  in  1  redirect request, single-cycle pulse or level.
- JUMP_ADDR  in  ADDR_WIDTH  redirect target; valid when JUMP=1.
- INSTR  out  8  instruction byte at the FIFO head.
- INSTR_ADDR  out  ADDR_WIDTH  ROM address of INSTR.
- INSTR_VALID  out  1  FIFO non-empty.
- INSTR_READY  in  1  consumer accepts INSTR this cycle.

## Operation
- State:
  - fetch pointer FPC;
  - FIFO of {addr, data} entries with count 0..DEPTH;
  - in-flight flag PEND, with its address tag PADDR.
- ROM_ADDR is combinational: JUMP_ADDR when JUMP=1 and RESETN=1, otherwise FPC.
- Issue condition: ISSUE = RESETN & (JUMP | (count + PEND < DEPTH)).
  - Count is taken before this cycle's pop; there is no pop credit.
- On ISSUE:
  - PEND←1 and PADDR←ROM_ADDR;
  - FPC←ROM_ADDR+1, wrapping modulo 2**ADDR_WIDTH.
- Otherwise PEND←0 and FPC holds.
- Capture: when PEND=1 and JUMP=0, push {PADDR, ROM_DATA} into the FIFO.
- Pop: when INSTR_VALID & INSTR_READY, remove the head.
  - Push and pop may occur in the same cycle; count is unchanged.
- Jump in cycle J:
  - A handshake in cycle J completes normally.
  - At the end of cycle J the FIFO is emptied.
  - Any ROM_DATA returning in cycle J is discarded.
  - The ROM read at JUMP_ADDR is issued in cycle J.
- JUMP in consecutive cycles: the last one wins; each cycle re-flushes.
- Overflow is impossible by construction: count + PEND ≤ DEPTH always holds.
- No instruction may be lost or duplicated between jumps.
- Reset (RESETN=0 at a rising edge), including mid-operation:
  - FPC←0, PEND←0, FIFO emptied;
  - JUMP is ignored while RESETN=0.
- Reset values of outputs: INSTR_VALID=0, INSTR=0x00, INSTR_ADDR=0, ROM_ADDR=0.

## Timing
- Read latency: address issued in cycle t → ROM_DATA in t+1 → pushed at end of t+1 → INSTR_VALID in t+2.
- After reset release (first cycle with RESETN=1 is cycle 0):
  - address 0 issued in cycle 0;
  - INSTR_VALID=1 with INSTR_ADDR=0 in cycle 2.
- Jump latency: JUMP in cycle J → INSTR_VALID=0 in J+1 → INSTR_ADDR=JUMP_ADDR valid in J+2.
- Throughput: with INSTR_READY held high, one instruction per cycle is sustained, with consecutive addresses.
- While INSTR_VALID=1 and INSTR_READY=0, INSTR and INSTR_ADDR hold stable until a handshake or a JUMP.
- INSTR, INSTR_ADDR and INSTR_VALID are register outputs; no combinational path from INSTR_READY.
- ROM_ADDR has a combinational path from JUMP and JUMP_ADDR.

## Test plan
- Startup:
  - Stimulus: ROM[0..7]=0x10..0x17, release reset with INSTR_READY=1.
  - Required: INSTR_VALID rises in cycle 2; bytes 0x10,0x11,… with INSTR_ADDR 0,1,… on consecutive cycles.
- Backpressure:
  - Stimulus: drop INSTR_READY for 10 cycles mid-stream.
  - Required: count saturates at 4 and ROM_ADDR stops advancing; INSTR stays stable; on release, delivery resumes with no gap or duplicate address.
- Jump with full FIFO:
  - Stimulus: 3 entries buffered; JUMP=1, JUMP_ADDR=0x80 in cycle J.
  - Required: INSTR_VALID=0 in J+1; INSTR_ADDR=0x80 with ROM[0x80] in J+2; no pre-jump address appears afterwards.
- Jump with same-cycle handshake:
  - Stimulus: JUMP and a handshake in the same cycle.
  - Required: the head is consumed exactly once; the next delivered address is JUMP_ADDR.
- Wrap-around:
  - Stimulus: JUMP to 0xFE with INSTR_READY=1.
  - Required: INSTR_ADDR sequence 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-operation:
  - Stimulus: RESETN=0 for one cycle with a full FIFO and PEND=1.
  - Required: INSTR_VALID=0 the next cycle; refetch restarts at address 0 with the startup timing.
